// File: rtl/ram_port_arbiter_if.sv
// Shared RAM port bundle: IF/LS request channels plus the RAM-side bus.
// The arbiter takes the slave view; the core/RAM environment takes the master view.
interface ram_port_arbiter_if #(
  parameter int ADR_W  = 8,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADR_W-1:0]  if_adr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_data;
  logic              ls_req;
  logic              ls_we;
  logic [ADR_W-1:0]  ls_adr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_valid;
  logic [DATA_W-1:0] ls_data;
  logic              ram_en;
  logic              ram_read;
  logic [ADR_W-1:0]  ram_adr;
  logic [DATA_W-1:0] ram_in;
  logic [DATA_W-1:0] ram_out;

  modport slave (
    input  if_req, if_adr,
    input  ls_req, ls_we, ls_adr, ls_wdata,
    input  ram_out,
    output if_gnt, if_valid, if_data,
    output ls_gnt, ls_valid, ls_data,
    output ram_en, ram_read, ram_adr, ram_in
  );

  modport master (
    output if_req, if_adr,
    output ls_req, ls_we, ls_adr, ls_wdata,
    output ram_out,
    input  if_gnt, if_valid, if_data,
    input  ls_gnt, ls_valid, ls_data,
    input  ram_en, ram_read, ram_adr, ram_in
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single RAM port between IF and LS (ACCESS then RESP).
// Define RAM_ARB_RR_EN for round-robin; default is LS priority with IF starvation guard.
module ram_port_arbiter #(
  parameter int ADR_W    = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } own_t;

  state_t            state_q;
  own_t              own_q;
  logic              ls_rd_q;
  logic              if_gnt_q;
  logic              ls_gnt_q;
  logic              if_valid_q;
  logic              ls_valid_q;
  logic              ram_en_q;
  logic              ram_read_q;
  logic [ADR_W-1:0]  ram_adr_q;
  logic [DATA_W-1:0] ram_in_q;

  logic arb;
  logic any_req;
  logic win_ls;

  assign arb     = (state_q != S_ACCESS);
  assign any_req = bus.if_req | bus.ls_req;

`ifdef RAM_ARB_RR_EN
  logic last_ls_q;
  logic last_ls_d;

  // On contention the requester that did not win last time goes next
  always_comb begin
    win_ls    = bus.ls_req & (~bus.if_req | ~last_ls_q);
    last_ls_d = last_ls_q;
    if (arb && any_req) last_ls_d = win_ls;
  end

  always_ff @(posedge clk) begin
    if (rst) last_ls_q <= 1'b0;
    else     last_ls_q <= last_ls_d;
  end
`else
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_q;
  logic [CW-1:0] wait_d;
  logic          both;
  logic          force_if;

  always_comb begin
    both     = bus.if_req & bus.ls_req;
    force_if = both && (wait_q == CW'(MAX_WAIT));
    win_ls   = bus.ls_req & ~force_if;
    wait_d   = wait_q;
    if (arb) begin
      if (both && !force_if) wait_d = wait_q + CW'(1);
      else                   wait_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      own_q      <= OWN_IF;
      ls_rd_q    <= 1'b0;
      if_gnt_q   <= 1'b0;
      ls_gnt_q   <= 1'b0;
      if_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_read_q <= 1'b1;
      ram_adr_q  <= '0;
      ram_in_q   <= '0;
    end else begin
      if_gnt_q   <= 1'b0;
      ls_gnt_q   <= 1'b0;
      if_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_read_q <= 1'b1;
      unique case (state_q)
        S_ACCESS: begin
          state_q    <= S_RESP;
          if_valid_q <= (own_q == OWN_IF);
          ls_valid_q <= (own_q == OWN_LS);
        end
        S_IDLE, S_RESP: begin
          if (any_req) begin
            state_q  <= S_ACCESS;
            ram_en_q <= 1'b1;
            if (win_ls) begin
              own_q      <= OWN_LS;
              ls_gnt_q   <= 1'b1;
              ls_rd_q    <= ~bus.ls_we;
              ram_read_q <= ~bus.ls_we;
              ram_adr_q  <= bus.ls_adr;
              if (bus.ls_we) ram_in_q <= bus.ls_wdata;
            end else begin
              own_q     <= OWN_IF;
              if_gnt_q  <= 1'b1;
              ram_adr_q <= bus.if_adr;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM registers its output, so read data is live on ram_out during RESP
  assign bus.if_data  = if_valid_q ? bus.ram_out : '0;
  assign bus.ls_data  = (ls_valid_q && ls_rd_q) ? bus.ram_out : '0;
  assign bus.if_gnt   = if_gnt_q;
  assign bus.ls_gnt   = ls_gnt_q;
  assign bus.if_valid = if_valid_q;
  assign bus.ls_valid = ls_valid_q;
  assign bus.ram_en   = ram_en_q;
  assign bus.ram_read = ram_read_q;
  assign bus.ram_adr  = ram_adr_q;
  assign bus.ram_in   = ram_in_q;
endmodule
